// File: rtl/adxl345_i2c_target.sv
// I2C target emulating the ADXL345 register file at DEV_ADDR.
// Oversampled SCL/SDA, open-drain SDA, fabric-side sample load port.
module adxl345_i2c_target #(
    parameter logic [6:0]  DEV_ADDR = 7'h53,
    parameter int unsigned HOLD_CYC = 10
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic        sample_valid,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    output logic        busy,
    output logic        reg_wr,
    output logic [5:0]  reg_addr,
    output logic [7:0]  reg_wdata
);
    localparam int HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t        state, state_n;
    logic [2:0]    scl_sh, sda_sh;
    logic          scl_s, scl_d, sda_s, sda_d;
    logic          scl_rise, scl_fall, start_c, stop_c;
    logic          bit8, ro, wr_en;
    logic [7:0]    shreg, rx_byte;
    logic [3:0]    bit_cnt;
    logic          nine, rw;
    logic [5:0]    ptr;
    logic [7:0]    regs [64];
    logic [47:0]   shadow, smp;
    logic          pending;
    logic [HW-1:0] hold_cnt;
    logic          hold_act, hold_val;
    logic          sched, sched_val;

    // Synchronizer runs through reset so releasing reset never fakes an edge
    always_ff @(posedge CLOCK_50) begin
        scl_sh <= {scl_sh[1:0], scl_in};
        sda_sh <= {sda_sh[1:0], sda_in};
    end

    assign scl_s    = scl_sh[1];
    assign scl_d    = scl_sh[2];
    assign sda_s    = sda_sh[1];
    assign sda_d    = sda_sh[2];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_c  = scl_s & scl_d & ~sda_s & sda_d;
    assign stop_c   = scl_s & scl_d & sda_s & ~sda_d;

    assign rx_byte = {shreg[6:0], sda_s};
    assign bit8    = scl_rise && (bit_cnt == 4'd7);
    assign ro      = (ptr == 6'h00) || ((ptr >= 6'h32) && (ptr <= 6'h37));
    assign wr_en   = (state == WDATA) && bit8 && !ro;
    assign smp     = {sample_z, sample_y, sample_x};

    always_comb begin
        busy = 1'b0;
        unique case (state)
            ADDR_ACK, PTR, PTR_ACK, WDATA,
            WDATA_ACK, RDATA, RACK: busy = 1'b1;
            default:                busy = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // sched asks for sda_oe <= sched_val HOLD_CYC cycles after this SCL fall
    always_comb begin
        state_n   = state;
        sched     = 1'b0;
        sched_val = 1'b0;
        if (start_c) begin
            state_n = ADDR;
        end else if (stop_c) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE, IGNORE: begin
                end
                ADDR: begin
                    if (bit8)
                        state_n = (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                end
                PTR: begin
                    if (bit8)
                        state_n = PTR_ACK;
                end
                WDATA: begin
                    if (bit8)
                        state_n = WDATA_ACK;
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sched     = 1'b1;
                        sched_val = ~nine;
                        if (nine) begin
                            if (state == ADDR_ACK && rw) begin
                                state_n   = RDATA;
                                sched_val = ~regs[ptr][7];
                            end else if (state == ADDR_ACK) begin
                                state_n = PTR;
                            end else begin
                                state_n = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        sched = 1'b1;
                        if (bit_cnt == 4'd0) begin
                            sched_val = ~shreg[7];
                        end else if (bit_cnt == 4'd8) begin
                            sched_val = 1'b0;
                            state_n   = RACK;
                        end else begin
                            sched_val = ~shreg[6];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise)
                        state_n = sda_s ? IGNORE : RDATA;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sda_oe    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= 6'h00;
            reg_wdata <= 8'h00;
            ptr       <= 6'h00;
            shreg     <= 8'h00;
            bit_cnt   <= 4'd0;
            nine      <= 1'b0;
            rw        <= 1'b0;
            hold_cnt  <= '0;
            hold_act  <= 1'b0;
            hold_val  <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            if (hold_act) begin
                if (hold_cnt == '0) begin
                    sda_oe   <= hold_val;
                    hold_act <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end
            if (sched) begin
                hold_act <= 1'b1;
                hold_cnt <= HW'(HOLD_CYC - 1);
                hold_val <= sched_val;
            end
            if (start_c || stop_c) begin
                sda_oe   <= 1'b0;
                hold_act <= 1'b0;
                bit_cnt  <= 4'd0;
                nine     <= 1'b0;
            end else begin
                unique case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit8 ? 4'd0 : bit_cnt + 4'd1;
                            nine    <= 1'b0;
                        end
                        if (bit8) begin
                            if (state == ADDR)
                                rw <= rx_byte[0];
                            else if (state == PTR)
                                ptr <= rx_byte[5:0];
                            else begin
                                ptr    <= ptr + 6'd1;
                                reg_wr <= !ro;
                                if (!ro) begin
                                    reg_addr  <= ptr;
                                    reg_wdata <= rx_byte;
                                end
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_rise)
                            nine <= 1'b1;
                        if (scl_fall && nine) begin
                            nine    <= 1'b0;
                            bit_cnt <= 4'd0;
                            if (state == ADDR_ACK && rw)
                                shreg <= regs[ptr];
                        end
                    end
                    RDATA: begin
                        if (scl_rise)
                            bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall && bit_cnt == 4'd8)
                            bit_cnt <= 4'd0;
                        else if (scl_fall && bit_cnt != 4'd0)
                            shreg <= {shreg[6:0], 1'b0};
                    end
                    RACK: begin
                        if (scl_rise) begin
                            ptr   <= ptr + 6'd1;
                            shreg <= regs[ptr + 6'd1];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // 0x32-0x37 only change between transactions so a burst sees one sample
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < 64; i++)
                regs[6'(i)] <= 8'h00;
            regs[6'h00] <= 8'hE5;
            regs[6'h2C] <= 8'h0A;
            shadow      <= '0;
            pending     <= 1'b0;
        end else begin
            if (wr_en)
                regs[ptr] <= rx_byte;
            if (sample_valid) begin
                shadow  <= smp;
                pending <= busy;
                if (!busy)
                    for (int k = 0; k < 6; k++)
                        regs[6'(50 + k)] <= smp[8*k +: 8];
            end else if (pending && !busy) begin
                pending <= 1'b0;
                for (int k = 0; k < 6; k++)
                    regs[6'(50 + k)] <= shadow[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_adxl345_i2c_target.sv
// Bench: bit-banged I2C initiator, register-map model, queue scoreboard.
// Monitor process pops expected values as observations arrive.
module tb_adxl345_i2c_target;
    localparam int Q = 32;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
    logic        sda_oe, busy, reg_wr;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        sda_line;

    int    n_tests = 0, n_fail = 0, oe_cnt = 0;
    int    exp_q[$], obs_q[$], wr_q[$];
    string nam_q[$];

    logic [7:0]  model [64];
    int          ptr_m;
    logic [47:0] shadow_m;
    bit          pend_m;
    logic [15:0] nx, ny, nz;

    assign sda_line = sda_m & ~sda_oe;

    always #10 CLOCK_50 = ~CLOCK_50;

    adxl345_i2c_target dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .scl_in       (scl),
        .sda_in       (sda_line),
        .sda_oe       (sda_oe),
        .sample_valid (sample_valid),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .sample_z     (sample_z),
        .busy         (busy),
        .reg_wr       (reg_wr),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata)
    );

    initial begin : monitor
        int    e, g;
        string nm;
        forever begin
            @(negedge CLOCK_50);
            if (sda_oe)
                oe_cnt++;
            if (reg_wr) begin
                n_tests++;
                g = int'({reg_addr, reg_wdata});
                if (wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL reg_wr: got addr/data %0h, required no write", g);
                end else begin
                    e = wr_q.pop_front();
                    if (g != e) begin
                        n_fail++;
                        $display("FAIL reg_wr: got addr/data %0h required %0h", g, e);
                    end
                end
            end
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                g  = obs_q.pop_front();
                e  = exp_q.pop_front();
                nm = nam_q.pop_front();
                n_tests++;
                if (g != e) begin
                    n_fail++;
                    $display("FAIL %s: got %0h required %0h", nm, g, e);
                end
            end
        end
    end

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic expect_v(input string nm, input int v);
        exp_q.push_back(v);
        nam_q.push_back(nm);
    endtask

    task automatic chk(input string nm, input int got, input int v);
        expect_v(nm, v);
        obs_q.push_back(got);
    endtask

    task automatic m_reset;
        for (int i = 0; i < 64; i++)
            model[i] = 8'h00;
        model[0]  = 8'hE5;
        model[44] = 8'h0A;
        ptr_m  = 0;
        pend_m = 1'b0;
    endtask

    task automatic m_apply;
        for (int k = 0; k < 6; k++)
            model[50 + k] = shadow_m[8*k +: 8];
    endtask

    task automatic m_end;
        if (pend_m) begin
            m_apply();
            pend_m = 1'b0;
        end
    endtask

    task automatic m_write(input logic [7:0] d);
        if (!(ptr_m == 0 || (ptr_m >= 50 && ptr_m <= 55))) begin
            model[ptr_m] = d;
            wr_q.push_back(int'({ptr_m[5:0], d}));
        end
        ptr_m = (ptr_m + 1) % 64;
    endtask

    task automatic load(input logic [15:0] x, y, z, input bit in_txn);
        @(negedge CLOCK_50);
        sample_x = x;
        sample_y = y;
        sample_z = z;
        sample_valid = 1'b1;
        @(negedge CLOCK_50);
        sample_valid = 1'b0;
        shadow_m = {z, y, x};
        if (in_txn)
            pend_m = 1'b1;
        else
            m_apply();
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; clk(Q);
        scl = 1'b1;   clk(Q);
        sda_m = 1'b0; clk(Q);
        scl = 1'b0;   clk(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; clk(Q);
        scl = 1'b1;   clk(Q);
        sda_m = 1'b1; clk(2*Q);
    endtask

    task automatic put_bit(input bit b);
        sda_m = b;  clk(Q);
        scl = 1'b1; clk(2*Q);
        scl = 1'b0; clk(Q);
    endtask

    task automatic get_bit(output bit b);
        sda_m = 1'b1; clk(Q);
        scl = 1'b1;   clk(Q);
        b = sda_line; clk(Q);
        scl = 1'b0;   clk(Q);
    endtask

    task automatic send(input logic [7:0] b, input bit exp_ack, input string nm);
        bit a;
        expect_v(nm, exp_ack);
        for (int i = 7; i >= 0; i--)
            put_bit(b[i]);
        get_bit(a);
        obs_q.push_back(a);
    endtask

    task automatic recv(input bit nack, input string nm);
        logic [7:0] b;
        bit         x;
        expect_v(nm, model[ptr_m]);
        ptr_m = (ptr_m + 1) % 64;
        for (int i = 7; i >= 0; i--) begin
            get_bit(x);
            b[i] = x;
        end
        put_bit(nack);
        obs_q.push_back(b);
    endtask

    task automatic wr_txn(input logic [7:0] p, input int n, input logic [7:0] d0, d1);
        i2c_start();
        send(8'hA6, 1'b0, "addr_w ack");
        chk("busy in write", busy, 1);
        send(p, 1'b0, "ptr ack");
        ptr_m = p[5:0];
        m_write(d0);
        send(d0, 1'b0, "wdata ack");
        if (n > 1) begin
            m_write(d1);
            send(d1, 1'b0, "wdata ack");
        end
        i2c_stop();
        m_end();
        clk(8);
        chk("busy after stop", busy, 0);
    endtask

    task automatic rd_txn(input logic [7:0] p, input int n, input int inj);
        int oe0;
        i2c_start();
        send(8'hA6, 1'b0, "addr_w ack");
        send(p, 1'b0, "ptr ack");
        ptr_m = p[5:0];
        i2c_start();
        send(8'hA7, 1'b0, "addr_r ack");
        chk("busy in read", busy, 1);
        for (int i = 0; i < n; i++) begin
            if (i == inj)
                load(nx, ny, nz, 1'b1);
            recv(i == n - 1, "rdata");
        end
        oe0 = oe_cnt;
        i2c_stop();
        m_end();
        clk(8);
        chk("busy after stop", busy, 0);
        chk("no drive after nack", oe_cnt - oe0, 0);
    endtask

    initial begin : stim
        int  oe0;
        bit  x;
        logic [7:0] p, a, b;

        m_reset();
        clk(6);
        reset = 1'b0;
        clk(2);
        chk("reset sda_oe", sda_oe, 0);
        chk("reset busy", busy, 0);
        chk("reset reg_wr", reg_wr, 0);
        chk("reset reg_addr", reg_addr, 0);
        chk("reset reg_wdata", reg_wdata, 0);

        wr_txn(8'h31, 1, 8'h0B, 8'h00);
        rd_txn(8'h31, 1, -1);
        rd_txn(8'h00, 2, -1);

        oe0 = oe_cnt;
        i2c_start();
        send(8'h3A, 1'b1, "foreign addr nack");
        chk("busy foreign", busy, 0);
        send(8'h55, 1'b1, "foreign data nack");
        i2c_stop();
        clk(8);
        chk("foreign never drives", oe_cnt - oe0, 0);

        load(16'h1234, 16'hFFFE, 16'h0100, 1'b0);
        nx = 16'hA5C3;
        ny = 16'h5A7E;
        nz = 16'h8001;
        rd_txn(8'h32, 6, 3);
        rd_txn(8'h32, 6, -1);

        a = 8'($urandom);
        b = 8'($urandom);
        wr_txn(8'h3F, 2, a, b);
        rd_txn(8'h00, 1, -1);

        for (int it = 0; it < 2; it++) begin
            p = 8'($urandom);
            load(16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            wr_txn(p, 1 + (it % 2), 8'($urandom), 8'($urandom));
            rd_txn(p, 2, -1);
        end

        i2c_start();
        send(8'hA6, 1'b0, "addr_w ack");
        send(8'h00, 1'b0, "ptr ack");
        i2c_start();
        send(8'hA7, 1'b0, "addr_r ack");
        for (int i = 0; i < 3; i++)
            get_bit(x);
        chk("driving devid bit4", sda_oe, 1);
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk("sda_oe after reset", sda_oe, 0);
        chk("busy after reset", busy, 0);
        chk("reg_addr after reset", reg_addr, 0);
        chk("reg_wdata after reset", reg_wdata, 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        m_reset();
        oe0 = oe_cnt;
        for (int i = 0; i < 6; i++)
            get_bit(x);
        i2c_stop();
        clk(8);
        chk("ignore after reset", oe_cnt - oe0, 0);
        rd_txn(8'hEC, 1, -1);

        clk(10);
        chk("writes drained", wr_q.size(), 0);
        clk(10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
